// File: rtl/approx_mul_iter.sv
// rtl/approx_mul_iter.sv - iterative approximate unsigned multiplier, one partial-product row per cycle
// Optional error monitor (exact shadow accumulator, err_dist, err_cnt): define APPROX_MUL_ERR_MON_EN
module approx_mul_iter #(
    parameter int WIDTH    = 6,
    parameter int DROP_COL = 6,
    parameter int ZERO_LSB = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p
`ifdef APPROX_MUL_ERR_MON_EN
    ,
    output logic [2*WIDTH-1:0]   err_dist,
    output logic [15:0]          err_cnt
`endif
);

    localparam int P_W = 2 * WIDTH;
    localparam int J_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    // Vector with every bit at or above lsb set; used for both column pruning and LSB zeroing.
    function automatic logic [P_W-1:0] keep_from(input int lsb);
        logic [P_W-1:0] m;
        for (int k = 0; k < P_W; k++) begin
            m[k] = (k >= lsb);
        end
        return m;
    endfunction

    localparam logic [P_W-1:0] COL_MASK  = keep_from(DROP_COL);
    localparam logic [P_W-1:0] ZERO_MASK = keep_from(ZERO_LSB);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [P_W-1:0]   acc;
    logic [J_W-1:0]   row;
    logic [P_W-1:0]   row_term;
    logic [P_W-1:0]   acc_sum;
    logic [P_W-1:0]   p_q;
    logic             out_valid_q;
    logic             accept;
    logic             deliver;
    logic             last_row;

    assign accept   = in_valid & in_ready;
    assign deliver  = out_valid_q & out_ready;
    assign last_row = (row == J_W'(WIDTH - 1));

    // Current pruned row: a shifted to row position, columns below DROP_COL removed, gated by b[row].
    always_comb begin
        row_term = '0;
        if (b_q[row]) begin
            row_term = (P_W'(a_q) << row) & COL_MASK;
        end
        acc_sum = acc + row_term;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and in_ready; DONE can hand off directly to BUSY when a new pair is waiting.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last_row) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    state_next = in_valid ? BUSY : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, row accumulation and registered result; p only changes on DONE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            acc         <= '0;
            row         <= '0;
            p_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                a_q <= a;
                b_q <= b;
                acc <= '0;
                row <= '0;
            end else if (state == BUSY) begin
                acc <= acc_sum;
                row <= row + J_W'(1);
            end
            if (state == BUSY && last_row) begin
                p_q <= acc_sum & ZERO_MASK;
            end
            out_valid_q <= (state_next == DONE);
        end
    end

    assign p         = p_q;
    assign out_valid = out_valid_q;

`ifdef APPROX_MUL_ERR_MON_EN
    logic [P_W-1:0] exact_acc;
    logic [P_W-1:0] exact_term;
    logic [P_W-1:0] exact_sum;
    logic [P_W-1:0] err_dist_q;
    logic [15:0]    err_cnt_q;

    // Unpruned row for the shadow accumulator.
    always_comb begin
        exact_term = '0;
        if (b_q[row]) begin
            exact_term = P_W'(a_q) << row;
        end
        exact_sum = exact_acc + exact_term;
    end

    // Shadow exact product, error distance latched with p, saturating count of erroneous deliveries.
    always_ff @(posedge clk) begin
        if (rst) begin
            exact_acc  <= '0;
            err_dist_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (accept) begin
                exact_acc <= '0;
            end else if (state == BUSY) begin
                exact_acc <= exact_sum;
            end
            if (state == BUSY && last_row) begin
                err_dist_q <= exact_sum - (acc_sum & ZERO_MASK);
            end
            if (deliver && (err_dist_q != '0) && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign err_dist = err_dist_q;
    assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_approx_mul_iter.sv
// tb/tb_approx_mul_iter.sv - directed bench for approx_mul_iter (default and exact configurations)
module tb_approx_mul_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [5:0]  a;
    logic [5:0]  b;

    logic        in_ready_d, out_valid_d;
    logic [11:0] p_d;
    logic        in_ready_x, out_valid_x;
    logic [11:0] p_x;
`ifdef APPROX_MUL_ERR_MON_EN
    logic [11:0] err_dist_d, err_dist_x;
    logic [15:0] err_cnt_d, err_cnt_x;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    approx_mul_iter #(.WIDTH(6), .DROP_COL(6), .ZERO_LSB(8)) dut_def (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_d),
        .a(a), .b(b), .out_valid(out_valid_d), .out_ready(out_ready), .p(p_d)
`ifdef APPROX_MUL_ERR_MON_EN
        , .err_dist(err_dist_d), .err_cnt(err_cnt_d)
`endif
    );

    approx_mul_iter #(.WIDTH(6), .DROP_COL(0), .ZERO_LSB(0)) dut_exact (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_x),
        .a(a), .b(b), .out_valid(out_valid_x), .out_ready(out_ready), .p(p_x)
`ifdef APPROX_MUL_ERR_MON_EN
        , .err_dist(err_dist_x), .err_cnt(err_cnt_x)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model(input int av, input int bv, input int drop, input int zlsb);
        int sum;
        sum = 0;
        for (int j = 0; j < 6; j++) begin
            for (int i = 0; i < 6; i++) begin
                if (av[i] && bv[j] && (i + j >= drop)) begin
                    sum += (1 << (i + j));
                end
            end
        end
        return sum & ~((1 << zlsb) - 1);
    endfunction

    task automatic do_op(input int av, input int bv, input int exp_d, input int exp_x,
                         input int exp_err_d, input int exp_cnt_d, input string tag);
        int lat;
        a = 6'(av);
        b = 6'(bv);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        check_eq({tag, "_in_ready"}, 32'(in_ready_d), 32'd1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid_d && lat < 30) begin
            tick();
            lat++;
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'd7);
        check_eq({tag, "_p_def"}, 32'(p_d), 32'(exp_d));
        check_eq({tag, "_p_exact"}, 32'(p_x), 32'(exp_x));
`ifdef APPROX_MUL_ERR_MON_EN
        check_eq({tag, "_err_dist_def"}, 32'(err_dist_d), 32'(exp_err_d));
        check_eq({tag, "_err_dist_exact"}, 32'(err_dist_x), 32'd0);
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, "_out_valid_after"}, 32'(out_valid_d), 32'd0);
`ifdef APPROX_MUL_ERR_MON_EN
        check_eq({tag, "_err_cnt_def"}, 32'(err_cnt_d), 32'(exp_cnt_d));
        check_eq({tag, "_err_cnt_exact"}, 32'(err_cnt_x), 32'd0);
`else
        if (exp_err_d < 0 || exp_cnt_d < 0) begin
            $display("bad vector %s", tag);
        end
`endif
    endtask

    initial begin
        int qd[$];
        int qx[$];
        int sent, got, cyc, last_cyc, hs, ov_seen;
        logic acc_now, stable;
        logic [11:0] p_hold;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        tick();
        tick();
        rst = 1'b0;
        check_eq("reset_in_ready", 32'(in_ready_d), 32'd1);
        check_eq("reset_out_valid", 32'(out_valid_d), 32'd0);
        check_eq("reset_p", 32'(p_d), 32'd0);
`ifdef APPROX_MUL_ERR_MON_EN
        check_eq("reset_err_dist", 32'(err_dist_d), 32'd0);
        check_eq("reset_err_cnt", 32'(err_cnt_d), 32'd0);
`endif

        // Directed vectors, expected values worked by hand.
        do_op(63, 63, 3584, 3969, 385, 1, "m63x63");
        do_op(1, 1, 0, 1, 1, 2, "m1x1");
        do_op(32, 32, 1024, 1024, 0, 2, "m32x32");
        do_op(0, 45, 0, 0, 0, 2, "m0x45");

        // Back-to-back: in_valid and out_ready held high for 8 pairs.
        sent = 0; got = 0; cyc = 0; last_cyc = -1;
        a = 6'($urandom_range(63)); b = 6'($urandom_range(63));
        in_valid = 1'b1; out_ready = 1'b1;
        while (got < 8 && cyc < 200) begin
            if (out_valid_d) begin
                if (qd.size() > 0) begin
                    check_eq("b2b_p_def", 32'(p_d), 32'(qd.pop_front()));
                    check_eq("b2b_p_exact", 32'(p_x), 32'(qx.pop_front()));
                end else begin
                    check_eq("b2b_unexpected_result", 32'd1, 32'd0);
                end
                check_eq("b2b_in_ready_done", 32'(in_ready_d), 32'd1);
                if (last_cyc >= 0) begin
                    check_eq("b2b_period", 32'(cyc - last_cyc), 32'd7);
                end
                last_cyc = cyc;
                got++;
            end
            acc_now = in_valid && in_ready_d;
            if (acc_now) begin
                qd.push_back(model(int'(a), int'(b), 6, 8));
                qx.push_back(int'(a) * int'(b));
                sent++;
            end
            tick();
            cyc++;
            if (acc_now) begin
                if (sent < 8) begin
                    a = 6'($urandom_range(63));
                    b = 6'($urandom_range(63));
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check_eq("b2b_results", 32'(got), 32'd8);
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();

        // Backpressure: result held for 20 cycles while a new pair is offered.
        a = 6'd45; b = 6'd27; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid_d && cyc < 30) begin
            tick();
            cyc++;
        end
        check_eq("bp_out_valid", 32'(out_valid_d), 32'd1);
        check_eq("bp_p", 32'(p_d), 32'(model(45, 27, 6, 8)));
        p_hold = p_d;
        stable = 1'b1;
        a = 6'd7; b = 6'd9; in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (in_ready_d || !out_valid_d || p_d != p_hold) stable = 1'b0;
            tick();
        end
        check_eq("bp_stall_stable", 32'(stable), 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        hs = 0;
        for (int k = 0; k < 5; k++) begin
            if (out_valid_d && out_ready) hs++;
            tick();
        end
        check_eq("bp_handshakes", 32'(hs), 32'd1);
        check_eq("bp_p_after", 32'(p_d), 32'(p_hold));
        out_ready = 1'b0;

        // Abort: reset during the third BUSY cycle.
        a = 6'd63; b = 6'd63; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_in_ready", 32'(in_ready_d), 32'd1);
        check_eq("abort_out_valid", 32'(out_valid_d), 32'd0);
        check_eq("abort_p", 32'(p_d), 32'd0);
`ifdef APPROX_MUL_ERR_MON_EN
        check_eq("abort_err_cnt", 32'(err_cnt_d), 32'd0);
`endif
        out_ready = 1'b1;
        ov_seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid_d) ov_seen++;
            tick();
        end
        check_eq("abort_no_result", 32'(ov_seen), 32'd0);
        out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
